// File: rtl/alu_pkg.sv
// alu_pkg -- definitions shared by the issue stage and the ALU.
//   alu_ctrl_e : 4-bit ALU control codes
//   OPC_*      : RV32I major opcodes recognised by the issue decoder
//   alu_op_t   : one decoded operation as handed to the ALU/execute stage
//   sext_12    : helper that sign-extends a 12-bit immediate to 32 bits
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLL    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_LD_ST  = 4'b1000,
    ALU_BRANCH = 4'b1001,
    ALU_SLT    = 4'b1100,
    ALU_SLTU   = 4'b1101
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    alu_ctrl_e   control;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_branch;
    logic [2:0]  funct3;
    logic        illegal;
  } alu_op_t;

  function automatic logic [31:0] sext_12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// alu_issue_dec -- purely combinational RV32I decode into an alu_op_t.
// Ports:
//   instr      : instruction word
//   pc         : instruction address (operand A for AUIPC/JAL/JALR)
//   rs1_data   : register-file read data for rs1
//   rs2_data   : register-file read data for rs2
//   op         : decoded operation (control, operands, rd/rd_we, flags)
module alu_issue_dec
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_op_t     op
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        f7_b5_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_u_s;
  logic [31:0] shamt_s;
  logic        is_shift_s;
  alu_op_t     op_s;

  assign opcode_s   = instr[6:0];
  assign funct3_s   = instr[14:12];
  assign f7_b5_s    = instr[30];
  assign imm_i_s    = sext_12(instr[31:20]);
  assign imm_s_s    = sext_12({instr[31:25], instr[11:7]});
  assign imm_u_s    = {instr[31:12], 12'h000};
  assign shamt_s    = {27'd0, instr[24:20]};
  assign is_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);

  // Arithmetic selection shared by OP and OP-IMM; only the register form
  // may turn funct3=000 into SUB (ADDI has no subtract variant).
  function automatic alu_ctrl_e arith_sel(input logic [2:0] f3,
                                          input logic       f7b5,
                                          input logic       is_reg);
    alu_ctrl_e c;
    case (f3)
      3'b000:  c = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      3'b111:  c = ALU_AND;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

  // Opcode decode; unknown opcodes fall into a zeroed illegal op.
  always_comb begin
    op_s           = '0;
    op_s.control   = ALU_ADD;
    op_s.funct3    = funct3_s;
    op_s.rd        = instr[11:7];
    case (opcode_s)
      OPC_OP: begin
        op_s.control = arith_sel(funct3_s, f7_b5_s, 1'b1);
        op_s.a       = rs1_data;
        op_s.b       = rs2_data;
        op_s.rd_we   = 1'b1;
      end
      OPC_OP_IMM: begin
        op_s.control = arith_sel(funct3_s, f7_b5_s, 1'b0);
        op_s.a       = rs1_data;
        op_s.b       = is_shift_s ? shamt_s : imm_i_s;
        op_s.rd_we   = 1'b1;
      end
      OPC_LOAD: begin
        op_s.control = ALU_LD_ST;
        op_s.a       = rs1_data;
        op_s.b       = imm_i_s;
        op_s.rd_we   = 1'b1;
      end
      OPC_STORE: begin
        op_s.control = ALU_LD_ST;
        op_s.a       = rs1_data;
        op_s.b       = imm_s_s;
        op_s.rd_we   = 1'b0;
      end
      OPC_BRANCH: begin
        case (funct3_s)
          3'b100, 3'b101: op_s.control = ALU_SLT;
          3'b110, 3'b111: op_s.control = ALU_SLTU;
          default:        op_s.control = ALU_BRANCH;
        endcase
        op_s.a         = rs1_data;
        op_s.b         = rs2_data;
        op_s.is_branch = 1'b1;
        op_s.rd_we     = 1'b0;
      end
      OPC_LUI: begin
        op_s.a     = 32'd0;
        op_s.b     = imm_u_s;
        op_s.rd_we = 1'b1;
      end
      OPC_AUIPC: begin
        op_s.a     = pc;
        op_s.b     = imm_u_s;
        op_s.rd_we = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        op_s.a     = pc;
        op_s.b     = 32'd4;
        op_s.rd_we = 1'b1;
      end
      default: begin
        op_s.illegal = 1'b1;
        op_s.rd      = 5'd0;
        op_s.a       = 32'd0;
        op_s.b       = 32'd0;
        op_s.rd_we   = 1'b0;
      end
    endcase
    // x0 is hard-wired zero: never request a write to it.
    op_s.rd_we = op_s.rd_we & (op_s.rd != 5'd0);
  end

  assign op = op_s;

endmodule

// File: rtl/alu_issue.sv
// alu_issue -- issue stage between register read and the ALU.
// Decodes one RV32I instruction per transfer and presents it, registered,
// to the execute stage one cycle after acceptance.
// Build option: define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with a
// registered in_ready; otherwise a single output register whose in_ready
// depends combinationally on out_ready.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : upstream handshake
//   in_instr, in_pc            : instruction word and its address
//   in_rs1_data, in_rs2_data   : register-file read data
//   out_valid/out_ready        : downstream handshake
//   out_a, out_b, out_control  : ALU operands and control code
//   out_rd, out_rd_we          : destination register and write enable
//   out_is_branch, out_funct3  : branch flag and condition for branch unit
//   out_illegal                : unsupported opcode flag
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_control,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_is_branch,
  output logic [2:0]      out_funct3,
  output logic            out_illegal
);

  alu_op_t dec_op_s;
  alu_op_t out_r;
  logic    out_valid_r;
  logic    out_free_s;
  logic    accept_s;

  alu_issue_dec u_dec (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .op       (dec_op_s)
  );

  // Output register can take a new op when empty or draining this cycle.
  assign out_free_s = !out_valid_r || out_ready;

`ifdef ALU_ISSUE_SKID_EN
  alu_op_t skid_r;
  logic    skid_valid_r;

  // in_ready comes only from flops, breaking the out_ready -> in_ready path.
  assign in_ready = rst_n && !skid_valid_r;
  assign accept_s = in_valid && in_ready;

  // Output/skid registers: skid entry drains first to keep ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_r        <= '0;
      skid_valid_r <= 1'b0;
      skid_r       <= '0;
    end else begin
      if (out_free_s) begin
        if (skid_valid_r) begin
          out_r        <= skid_r;
          out_valid_r  <= 1'b1;
          skid_valid_r <= 1'b0;
        end else if (accept_s) begin
          out_r       <= dec_op_s;
          out_valid_r <= 1'b1;
        end else begin
          out_valid_r <= 1'b0;
        end
      end else if (accept_s) begin
        // Output stalled: park the arriving op in the skid entry.
        skid_r       <= dec_op_s;
        skid_valid_r <= 1'b1;
      end else begin
        skid_valid_r <= skid_valid_r;
      end
    end
  end
`else
  assign in_ready = rst_n && out_free_s;
  assign accept_s = in_valid && in_ready;

  // Single output register; data held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_r       <= '0;
    end else begin
      if (accept_s) begin
        out_r       <= dec_op_s;
        out_valid_r <= 1'b1;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end
`endif

  assign out_valid     = out_valid_r;
  assign out_a         = out_r.a;
  assign out_b         = out_r.b;
  assign out_control   = out_r.control;
  assign out_rd        = out_r.rd;
  assign out_rd_we     = out_r.rd_we;
  assign out_is_branch = out_r.is_branch;
  assign out_funct3    = out_r.funct3;
  assign out_illegal   = out_r.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue -- directed self-checking bench for alu_issue.
// Honours ALU_ISSUE_SKID_EN for the acceptance timing under back-pressure.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic [31:0] in_rs1_data = 32'd0;
  logic [31:0] in_rs2_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_control;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_is_branch;
  logic [2:0]  out_funct3;
  logic        out_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_control   (out_control),
    .out_rd        (out_rd),
    .out_rd_we     (out_rd_we),
    .out_is_branch (out_is_branch),
    .out_funct3    (out_funct3),
    .out_illegal   (out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  // Present one op, wait (bounded) for acceptance, then drop in_valid.
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    int w;
    in_instr = instr; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic we,
                           input logic br, input logic [2:0] f3, input logic ill);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".ctrl"},  {28'd0, out_control}, {28'd0, ctrl});
    check({tag, ".a"},     out_a, a);
    check({tag, ".b"},     out_b, b);
    check({tag, ".rd"},    {27'd0, out_rd}, {27'd0, rd});
    check({tag, ".we"},    {31'd0, out_rd_we}, {31'd0, we});
    check({tag, ".br"},    {31'd0, out_is_branch}, {31'd0, br});
    check({tag, ".f3"},    {29'd0, out_funct3}, {29'd0, f3});
    check({tag, ".ill"},   {31'd0, out_illegal}, {31'd0, ill});
  endtask

  // R-type control table: {funct7[5], funct3} -> control
  logic [3:0] r_key [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                             4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
  logic [3:0] r_exp [10] = '{4'b0000, 4'b0001, 4'b0101, 4'b1100, 4'b1101,
                             4'b0100, 4'b0110, 4'b0111, 4'b0011, 4'b0010};
  logic [31:0] bp_a [3] = '{32'd100, 32'd200, 32'd300};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc [3];
    int nsent, nrecv;
    logic stall_prev;
    logic [31:0] prev_a;
    logic [3:0]  prev_ctrl;
    logic [3:0]  key;

    // ---- reset state ----
    #2 rst_n = 1'b0;
    #1;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd0);
    check("rst.ctrl", {28'd0, out_control}, 32'd0);
    check("rst.a", out_a, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- single ops, out_ready held high ----
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h0, 32'd5, 32'd7);
    expect_op("add", 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd4, 7'b0010011), 32'h0, 32'h8000_0000, 32'd9);
    expect_op("srai", 4'b0111, 32'h8000_0000, 32'd3, 5'd4, 1'b1, 1'b0, 3'b101, 1'b0);
    drive(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011), 32'h0, 32'd10, 32'd3);
    expect_op("sub", 4'b0001, 32'd10, 32'd3, 5'd5, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011), 32'h0, 32'd1, 32'd2);
    expect_op("bltu", 4'b1101, 32'd1, 32'd2, 5'd0, 1'b0, 1'b1, 3'b110, 1'b0);
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd0, 7'b1100011), 32'h0, 32'd4, 32'd6);
    expect_op("bge", 4'b1100, 32'd4, 32'd6, 5'd0, 1'b0, 1'b1, 3'b101, 1'b0);
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011), 32'h0, 32'd4, 32'd6);
    expect_op("beq", 4'b1001, 32'd4, 32'd6, 5'd0, 1'b0, 1'b1, 3'b000, 1'b0);
    drive(enc_i(12'hFFB, 5'd1, 3'b000, 5'd7, 7'b0010011), 32'h0, 32'd20, 32'd0);
    expect_op("addi_neg", 4'b0000, 32'd20, 32'hFFFF_FFFB, 5'd7, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(enc_i(12'd16, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'h0, 32'h1000, 32'd0);
    expect_op("lw", 4'b1000, 32'h1000, 32'd16, 5'd6, 1'b1, 1'b0, 3'b010, 1'b0);
    drive(32'hFE20_AE23, 32'h0, 32'h2000, 32'd77);
    expect_op("sw", 4'b1000, 32'h2000, 32'hFFFF_FFFC, 5'h1C, 1'b0, 1'b0, 3'b010, 1'b0);
    drive({20'h12345, 5'd8, 7'b0110111}, 32'h40, 32'd9, 32'd9);
    expect_op("lui", 4'b0000, 32'd0, 32'h1234_5000, 5'd8, 1'b1, 1'b0, 3'b101, 1'b0);
    drive({20'h00001, 5'd9, 7'b0010111}, 32'h100, 32'd9, 32'd9);
    expect_op("auipc", 4'b0000, 32'h100, 32'h1000, 5'd9, 1'b1, 1'b0, 3'b001, 1'b0);
    drive({20'h00000, 5'd1, 7'b1101111}, 32'h200, 32'd9, 32'd9);
    expect_op("jal", 4'b0000, 32'h200, 32'd4, 5'd1, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(32'h0000_007F, 32'h300, 32'h55, 32'h66);
    expect_op("illegal", 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 3'b000, 1'b1);
    drive(enc_i(12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'h0, 32'd0, 32'd0);
    expect_op("addi_x0", 4'b0000, 32'd0, 32'd1, 5'd0, 1'b0, 1'b0, 3'b000, 1'b0);

    // ---- R-type control table ----
    for (int i = 0; i < 10; i++) begin
      key = r_key[i];
      drive(enc_r({1'b0, key[3], 5'd0}, 5'd2, 5'd1, key[2:0], 5'd11, 7'b0110011),
            32'h0, 32'd1, 32'd2);
      check($sformatf("rtab%0d.ctrl", i), {28'd0, out_control}, {28'd0, r_exp[i]});
    end

    // ---- back-pressure: 3 back-to-back ops, out_ready low for cycles 0..3 ----
    @(posedge clk); #1;
    check("bp.idle", {31'd0, out_valid}, 32'd0);
    nsent = 0; nrecv = 0; stall_prev = 1'b0; prev_a = 32'd0; prev_ctrl = 4'd0;
    for (int i = 0; i < 3; i++) acc_cyc[i] = -1;
    for (int cyc = 0; cyc < 30 && nrecv < 3; cyc++) begin
      out_ready = (cyc >= 4);
      if (nsent < 3) begin
        in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd12, 7'b0110011);
        in_rs1_data = bp_a[nsent];
        in_rs2_data = 32'd1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_prev) begin
        check("bp.hold_a", out_a, prev_a);
        check("bp.hold_ctrl", {28'd0, out_control}, {28'd0, prev_ctrl});
      end
      if (out_valid && out_ready) begin
        if (nrecv < 3) check($sformatf("bp.order%0d", nrecv), out_a, bp_a[nrecv]);
        nrecv++;
      end
      if (in_valid && in_ready) begin
        acc_cyc[nsent] = cyc;
        nsent++;
      end
      stall_prev = out_valid && !out_ready;
      prev_a = out_a;
      prev_ctrl = out_control;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp.count", nrecv, 32'd3);
    check("bp.acc0", acc_cyc[0], 32'd0);
`ifdef ALU_ISSUE_SKID_EN
    check("bp.acc1", acc_cyc[1], 32'd1);
`else
    check("bp.acc1", acc_cyc[1], 32'd4);
`endif
    check("bp.acc2", acc_cyc[2], 32'd5);
    repeat (2) begin
      @(posedge clk); #1;
      check("bp.no_dup", {31'd0, out_valid}, 32'd0);
    end

    // ---- reset while stalled with a valid op ----
    out_ready = 1'b0;
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd13, 7'b0110011), 32'h0, 32'hF0, 32'h3C);
    check("rst2.pre_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst2.valid", {31'd0, out_valid}, 32'd0);
    check("rst2.in_ready", {31'd0, in_ready}, 32'd0);
    check("rst2.a", out_a, 32'd0);
    check("rst2.ctrl", {28'd0, out_control}, 32'd0);
    check("rst2.we", {31'd0, out_rd_we}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst2.quiet", {31'd0, out_valid}, 32'd0);
    end
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd13, 7'b0110011), 32'h0, 32'hF0, 32'h3C);
    expect_op("post_rst_and", 4'b0010, 32'hF0, 32'h3C, 5'd13, 1'b1, 1'b0, 3'b111, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
